// File: rtl/dispatch_buffer.sv
// Circular instruction FIFO between decode and the issue queue.
// Optional same-cycle bypass into an empty buffer: define DISPATCH_BYPASS_EN.
module dispatch_buffer #(
    parameter int NUM_ENTRIES  = 4,
    parameter int ENTRY_WIDTH  = 2,
    parameter int AL_FUNC_W    = 4,
    parameter int REG_ADDR_LEN = 5
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    flush,
    input  logic                    in_valid,
    input  logic [AL_FUNC_W-1:0]    in_insn,
    input  logic [REG_ADDR_LEN-1:0] in_inp1,
    input  logic [REG_ADDR_LEN-1:0] in_inp2,
    input  logic [REG_ADDR_LEN-1:0] in_dst,
    output logic                    in_ready,
    input  logic                    iq_full,
    output logic                    load,
    output logic [AL_FUNC_W-1:0]    insn,
    output logic [REG_ADDR_LEN-1:0] inp1,
    output logic [REG_ADDR_LEN-1:0] inp2,
    output logic [REG_ADDR_LEN-1:0] dst,
    output logic [ENTRY_WIDTH:0]    count
);

    localparam int                  ITEM_W     = AL_FUNC_W + 3 * REG_ADDR_LEN;
    localparam logic [ENTRY_WIDTH:0] FULL_COUNT = (ENTRY_WIDTH + 1)'(NUM_ENTRIES);

    logic [ITEM_W-1:0]      r_mem [NUM_ENTRIES];
    logic [ENTRY_WIDTH-1:0] r_head;
    logic [ENTRY_WIDTH-1:0] r_tail;
    logic [ENTRY_WIDTH:0]   r_count;

    logic              w_empty;
    logic              w_full;
    logic              w_bypass;
    logic              w_push;
    logic              w_pop;
    logic [ITEM_W-1:0] w_in_item;
    logic [ITEM_W-1:0] w_out_item;

    assign w_in_item = {in_insn, in_inp1, in_inp2, in_dst};
    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == FULL_COUNT);

`ifdef DISPATCH_BYPASS_EN
    // An instruction arriving at an empty buffer goes straight out and is never stored.
    assign w_bypass = w_empty && in_valid && !iq_full && !flush && !reset;
`else
    assign w_bypass = 1'b0;
`endif

    assign in_ready = !w_full && !flush;
    assign w_pop    = !w_empty && !iq_full && !flush && !reset;
    assign load     = w_pop || w_bypass;
    assign w_push   = in_valid && in_ready && !w_bypass;
    assign count    = r_count;

    always_comb begin
        w_out_item = '0;
        if (!w_empty) begin
            w_out_item = r_mem[r_head];
        end else if (w_bypass) begin
            w_out_item = w_in_item;
        end
    end

    assign {insn, inp1, inp2, dst} = w_out_item;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + ENTRY_WIDTH'(1);
            end
            if (w_pop) begin
                r_head <= r_head + ENTRY_WIDTH'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Payload storage carries no reset; validity is tracked by the pointers alone.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_tail] <= w_in_item;
        end
    end

endmodule

// File: tb/tb_dispatch_buffer.sv
// Randomised and directed bench for dispatch_buffer with a queue-based reference model.
// A monitor checks every delivered instruction against the expected-delivery queue.
module tb_dispatch_buffer;

    localparam int DEPTH  = 4;
    localparam int EW     = 2;
    localparam int FW     = 4;
    localparam int RW     = 5;
    localparam int ITEM_W = FW + 3 * RW;

`ifdef DISPATCH_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    localparam logic [FW-1:0] ALU_ADD = 4'd0;
    localparam logic [FW-1:0] ALU_SUB = 4'd1;
    localparam logic [FW-1:0] ALU_AND = 4'd2;
    localparam logic [FW-1:0] ALU_OR  = 4'd3;
    localparam logic [FW-1:0] ALU_XOR = 4'd4;
    localparam logic [FW-1:0] ALU_SLL = 4'd5;
    localparam logic [FW-1:0] ALU_SRL = 4'd6;

    logic          clk;
    logic          reset;
    logic          flush;
    logic          in_valid;
    logic [FW-1:0] in_insn;
    logic [RW-1:0] in_inp1;
    logic [RW-1:0] in_inp2;
    logic [RW-1:0] in_dst;
    logic          in_ready;
    logic          iq_full;
    logic          load;
    logic [FW-1:0] insn;
    logic [RW-1:0] inp1;
    logic [RW-1:0] inp2;
    logic [RW-1:0] dst;
    logic [EW:0]   count;

    dispatch_buffer #(
        .NUM_ENTRIES (DEPTH),
        .ENTRY_WIDTH (EW),
        .AL_FUNC_W   (FW),
        .REG_ADDR_LEN(RW)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .flush   (flush),
        .in_valid(in_valid),
        .in_insn (in_insn),
        .in_inp1 (in_inp1),
        .in_inp2 (in_inp2),
        .in_dst  (in_dst),
        .in_ready(in_ready),
        .iq_full (iq_full),
        .load    (load),
        .insn    (insn),
        .inp1    (inp1),
        .inp2    (inp2),
        .dst     (dst),
        .count   (count)
    );

    // Scoreboard: every accepted instruction, in the order it must be delivered.
    logic [ITEM_W-1:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: number of instructions the buffer should hold.
    int mcnt    = 0;
    bit p_flush = 1'b0;
    int p_inc   = 0;
    int p_dec   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [ITEM_W-1:0] mk(input logic [FW-1:0] f, input int a, input int b, input int d);
        return {f, RW'(a), RW'(b), RW'(d)};
    endfunction

    // Monitor: whenever the DUT strobes load, the presented instruction must be the oldest expected one.
    always @(negedge clk) begin
        if (!reset && load) begin
            if (exp_q.size() == 0) begin
                check("unexpected_load", 32'(load), 32'(0));
            end else begin
                check("deliver", 32'({insn, inp1, inp2, dst}), 32'(exp_q.pop_front()));
            end
        end
    end

    // One clock cycle of stimulus; the model decides acceptance, delivery and count from its own queue size.
    task automatic cycle(input logic v, input logic [ITEM_W-1:0] item, input logic f_iq, input logic f_fl);
        bit exp_ready;
        bit byp;
        bit exp_load;
        @(posedge clk);
        if (p_flush) begin
            mcnt = 0;
            exp_q.delete();
        end else begin
            mcnt = mcnt + p_inc - p_dec;
        end
        #1;
        in_valid = v;
        {in_insn, in_inp1, in_inp2, in_dst} = item;
        iq_full = f_iq;
        flush = f_fl;
        exp_ready = (mcnt != DEPTH) && !f_fl;
        byp = BYP && (mcnt == 0) && v && !f_iq && !f_fl;
        exp_load = ((mcnt != 0) && !f_iq && !f_fl) || byp;
        if (v && exp_ready) exp_q.push_back(item);
        p_flush = f_fl;
        p_inc = (v && exp_ready && !byp) ? 1 : 0;
        p_dec = ((mcnt != 0) && !f_iq && !f_fl) ? 1 : 0;
        #1;
        check("count", 32'(count), 32'(mcnt));
        check("in_ready", 32'(in_ready), 32'(exp_ready));
        check("load", 32'(load), 32'(exp_load));
        if (mcnt == 0 && !byp) check("idle_data", 32'({insn, inp1, inp2, dst}), 32'(0));
    endtask

    task automatic idle(input int n, input logic f_iq);
        for (int i = 0; i < n; i++) cycle(1'b0, '0, f_iq, 1'b0);
    endtask

    // Reset asserted between edges must clear the buffer before any clock arrives.
    task automatic do_reset();
        @(posedge clk);
        #3;
        in_valid = 1'b1;
        {in_insn, in_inp1, in_inp2, in_dst} = mk(ALU_OR, 7, 7, 7);
        iq_full = 1'b0;
        flush = 1'b0;
        reset = 1'b1;
        #1;
        check("rst_count", 32'(count), 32'(0));
        check("rst_load", 32'(load), 32'(0));
        check("rst_ready", 32'(in_ready), 32'(1));
        check("rst_data", 32'({insn, inp1, inp2, dst}), 32'(0));
        mcnt = 0;
        p_flush = 1'b0;
        p_inc = 0;
        p_dec = 0;
        exp_q.delete();
        @(posedge clk);
        #1;
        check("rst_hold_load", 32'(load), 32'(0));
        reset = 1'b0;
        in_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        flush = 1'b0;
        in_valid = 1'b0;
        {in_insn, in_inp1, in_inp2, in_dst} = '0;
        iq_full = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("init_count", 32'(count), 32'(0));
        check("init_load", 32'(load), 32'(0));
        check("init_ready", 32'(in_ready), 32'(1));
        check("init_data", 32'({insn, inp1, inp2, dst}), 32'(0));
        reset = 1'b0;

        // Basic FIFO order
        cycle(1'b1, mk(ALU_ADD, 1, 2, 3), 1'b0, 1'b0);
        cycle(1'b1, mk(ALU_SUB, 4, 5, 6), 1'b0, 1'b0);
        cycle(1'b1, mk(ALU_AND, 8, 9, 10), 1'b0, 1'b0);
        idle(3, 1'b0);

        // Full buffer with the issue queue stalled; SLL must be refused
        cycle(1'b1, mk(ALU_ADD, 1, 2, 3), 1'b1, 1'b0);
        cycle(1'b1, mk(ALU_SUB, 4, 5, 6), 1'b1, 1'b0);
        cycle(1'b1, mk(ALU_AND, 8, 9, 10), 1'b1, 1'b0);
        cycle(1'b1, mk(ALU_OR, 11, 12, 13), 1'b1, 1'b0);
        cycle(1'b1, mk(ALU_SLL, 15, 16, 17), 1'b1, 1'b0);
        cycle(1'b1, mk(ALU_SLL, 15, 16, 17), 1'b0, 1'b0);

        // Drain
        idle(6, 1'b0);

        // Simultaneous push and pop at count 2
        cycle(1'b1, mk(ALU_ADD, 1, 1, 1), 1'b1, 1'b0);
        cycle(1'b1, mk(ALU_SUB, 2, 2, 2), 1'b1, 1'b0);
        cycle(1'b1, mk(ALU_XOR, 12, 13, 14), 1'b0, 1'b0);
        idle(4, 1'b0);

        // Wrap-around then flush at count 3
        for (int i = 0; i < 6; i++) cycle(1'b1, mk(4'(i), i, i + 1, i + 2), 1'b0, 1'b0);
        idle(3, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b1, mk(ALU_AND, i, 20, 30), 1'b1, 1'b0);
        cycle(1'b1, mk(ALU_OR, 1, 2, 3), 1'b0, 1'b1);
        idle(2, 1'b0);

        // Reset mid-stream at count 2, then a push into an empty buffer
        cycle(1'b1, mk(ALU_ADD, 5, 6, 7), 1'b1, 1'b0);
        cycle(1'b1, mk(ALU_SUB, 8, 9, 10), 1'b1, 1'b0);
        do_reset();
        cycle(1'b1, mk(ALU_SRL, 19, 20, 21), 1'b0, 1'b0);
        idle(2, 1'b0);

        // Random traffic
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end else begin
                cycle(($urandom_range(0, 9) < 6),
                      mk(4'($urandom_range(0, 15)), $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31)),
                      ($urandom_range(0, 9) < 3),
                      ($urandom_range(0, 39) == 0));
            end
        end

        idle(DEPTH + 3, 1'b0);
        check("drain_empty", 32'(exp_q.size()), 32'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
